popcount_accumulator: RTL and testbench

POPCOUNT_ACCUMULATOR -- requirements
Module: popcount_accumulator

---
 rtl/popcount_accumulator_if.sv | 39 +++
 rtl/popcount_accumulator.sv | 72 +++++++
 tb/tb_popcount_accumulator.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/popcount_accumulator_if.sv
// Nibble-stream input and frame-result output of the popcount accumulator.
// The master drives nibbles in and takes results out; the slave is the accumulator.
interface popcount_accumulator_if #(
  parameter int unsigned FRAME_LEN = 8
);
  localparam int unsigned NIB_W   = $clog2(FRAME_LEN + 1);
  localparam int unsigned TOTAL_W = $clog2(4 * FRAME_LEN + 1);

  logic               in_valid;
  logic [3:0]         in_data;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic [TOTAL_W-1:0] out_total;
  logic [NIB_W-1:0]   out_nibbles;
  logic               out_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_total,
    input  out_nibbles
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_total,
    output out_nibbles
  );
endinterface

// File: rtl/popcount_accumulator.sv
// Counts set bits across a frame of nibbles, then holds the frame total and
// nibble count until the downstream side takes them.
module popcount_accumulator #(
  parameter int unsigned FRAME_LEN = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  popcount_accumulator_if.slave bus
);
  localparam int unsigned NIB_W   = $clog2(FRAME_LEN + 1);
  localparam int unsigned TOTAL_W = $clog2(4 * FRAME_LEN + 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e             state_q, state_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [NIB_W-1:0]   count_q, count_d;
  logic [2:0]         nib_pop;
  logic               accept;

  assign nib_pop = {2'b00, bus.in_data[0]} + {2'b00, bus.in_data[1]}
                 + {2'b00, bus.in_data[2]} + {2'b00, bus.in_data[3]};

  assign accept = (state_q == StAccum) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    count_d = count_q;
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          total_d = total_q + TOTAL_W'(nib_pop);
          count_d = count_q + NIB_W'(1);
          // A full frame and in_last on the same nibble still close only one frame.
          if (bus.in_last || (count_d == NIB_W'(FRAME_LEN))) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StAccum;
          total_d = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = StAccum;
        total_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAccum;
      total_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready    = (state_q == StAccum);
  assign bus.out_valid   = (state_q == StHold);
  assign bus.out_total   = total_q;
  assign bus.out_nibbles = count_q;
endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench for popcount_accumulator with FRAME_LEN = 4.
module tb_popcount_accumulator;
  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  popcount_accumulator_if #(.FRAME_LEN(4)) bus ();

  popcount_accumulator #(.FRAME_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic valid, input logic [31:0] total,
                         input logic [31:0] nibs);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
    chk({tag, ".total"}, 32'(bus.out_total), total);
    chk({tag, ".nibs"}, 32'(bus.out_nibbles), nibs);
    chk({tag, ".ready"}, 32'(bus.in_ready), 32'(!valid));
  endtask

  initial begin
    logic [6:0]  vpat;
    logic [15:0] dseq;
    int          k;
    compared   = 0;
    mismatched = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset for two cycles
    tick();
    tick();
    rst_n = 1'b1;
    chk_out("reset", 1'b0, 0, 0);

    // Full frame closed by the counter: F,0,5,8 -> 4+0+2+1 = 7
    send(4'hF, 1'b0);
    chk_out("full_1", 1'b0, 4, 1);
    send(4'h0, 1'b0);
    send(4'h5, 1'b0);
    chk_out("full_3", 1'b0, 6, 3);
    send(4'h8, 1'b0);
    chk_out("full_done", 1'b1, 7, 4);
    tick();
    chk_out("full_release", 1'b0, 0, 0);

    // Single nibble closed by in_last
    send(4'h3, 1'b1);
    chk_out("single", 1'b1, 2, 1);
    tick();
    chk_out("single_release", 1'b0, 0, 0);

    // Maximum total held while downstream stalls, with input pressure
    bus.out_ready = 1'b0;
    repeat (4) send(4'hF, 1'b0);
    chk_out("max_done", 1'b1, 16, 4);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("max_hold", 1'b1, 16, 4);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk_out("max_release", 1'b0, 0, 0);
    send(4'h1, 1'b1);
    chk_out("after_max", 1'b1, 1, 1);
    tick();

    // Reset mid-frame discards the partial frame
    send(4'h7, 1'b0);
    send(4'hE, 1'b0);
    chk_out("partial", 1'b0, 6, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("mid_reset", 1'b0, 0, 0);
    send(4'h1, 1'b1);
    chk_out("post_reset", 1'b1, 1, 1);
    tick();

    // Gapped valid: invalid cycles carry junk with in_last=1 that must be ignored
    vpat = 7'b1101001;
    dseq = 16'h8421;
    k    = 0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = vpat[i];
      if (vpat[i]) begin
        bus.in_data = dseq[4*k +: 4];
        bus.in_last = 1'b0;
        k++;
      end else begin
        bus.in_data = 4'hF;
        bus.in_last = 1'b1;
      end
      tick();
      if (i < 6) chk("gap_pending", 32'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk_out("gap_done", 1'b1, 4, 4);
    tick();

    // in_last on the nibble that also fills the frame closes a single frame
    send(4'h1, 1'b0);
    send(4'h3, 1'b0);
    send(4'h7, 1'b0);
    send(4'hA, 1'b1);
    chk_out("last_and_full", 1'b1, 8, 4);
    tick();
    chk_out("one_frame", 1'b0, 0, 0);
    tick();
    chk_out("idle", 1'b0, 0, 0);

    // Reset in HOLD wins over a simultaneous accept attempt and output handshake
    bus.out_ready = 1'b0;
    send(4'h6, 1'b1);
    chk_out("hold_pending", 1'b1, 2, 1);
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hF;
    bus.in_last   = 1'b1;
    tick();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk_out("hold_reset", 1'b0, 0, 0);
    tick();
    chk_out("hold_reset_idle", 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
